// File: rtl/bcd_display_scanner_if.sv
// Digit/segment bundle between a BCD counter chain and the display scanner.
// The master drives the count and controls; the slave returns the display lines.
interface bcd_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    blank_lz;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    frame_done;

    modport master (
        output en, blank_lz, bcd_in,
        input  an, seg, frame_done
    );

    modport slave (
        input  en, blank_lz, bcd_in,
        output an, seg, frame_done
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexes a packed BCD count onto one common 7-segment display, LSD first,
// with a per-frame snapshot, optional leading-zero blanking and a dash for non-BCD digits.
//
// state | meaning
// IDLE  | display dark, waiting for en
// SCAN  | cycling digits, each held REFRESH_DIV clocks
module bcd_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    bcd_display_scanner_if.slave       bus
);
    localparam int DIG_W = $clog2(NUM_DIGITS);
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(REFRESH_DIV - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_cnt;
    logic [DIG_W-1:0]        dig;
    logic [4*NUM_DIGITS-1:0] snap;
    logic                    frame_done_q;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_above;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   an_c;
    logic [6:0]              seg_c;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign tick = (div_cnt == LAST_DIV);
    assign wrap = tick && (dig == LAST_DIG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en)  state_d = SCAN;
            SCAN:    if (!bus.en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Prescaler, digit pointer, snapshot and frame marker; en=0 overrides tick and wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt      <= '0;
            dig          <= '0;
            snap         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_cnt <= '0;
                    dig     <= '0;
                    if (bus.en) snap <= bus.bcd_in;
                end
                SCAN: begin
                    if (!bus.en) begin
                        div_cnt <= '0;
                        dig     <= '0;
                    end else if (tick) begin
                        div_cnt <= '0;
                        if (wrap) begin
                            dig          <= '0;
                            snap         <= bus.bcd_in;
                            frame_done_q <= 1'b1;
                        end else begin
                            dig <= dig + DIG_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    div_cnt <= '0;
                    dig     <= '0;
                end
            endcase
        end
    end

    // lz_blank[i] is set when snapshot digits i..MSD are all zero.
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above && (snap[4*i +: 4] == 4'd0);
            lz_blank[i] = zero_above;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig == DIG_W'(i)) begin
                cur_digit = snap[4*i +: 4];
                cur_blank = (i != 0) && lz_blank[i];
            end
        end
    end

    always_comb begin
        an_c  = '0;
        seg_c = '0;
        case (state_q)
            SCAN: begin
                an_c  = NUM_DIGITS'(1) << dig;
                seg_c = (bus.blank_lz && cur_blank) ? 7'h00 : decode(cur_digit);
            end
            default: begin
                an_c  = '0;
                seg_c = '0;
            end
        endcase
    end

    assign bus.an         = an_c;
    assign bus.seg        = seg_c;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: the driver predicts each cycle's display
// from frame-position arithmetic and queues it; the monitor pops and compares.
module tb_bcd_display_scanner;
    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int FRAME = ND * RD;

    typedef struct {
        logic [ND-1:0] an;
        logic [6:0]    seg;
        logic          fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

    bcd_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    bit            m_scan = 0;
    int            m_k    = 0;
    logic [15:0]   m_snap = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    function automatic exp_t predict(input logic blz);
        exp_t e;
        int   d;
        e.an = '0; e.seg = '0; e.fd = 1'b0;
        if (m_scan) begin
            d    = (m_k / RD) % ND;
            e.an = ND'(1 << d);
            e.fd = (m_k > 0) && (m_k % FRAME == 0);
            if (blz && d > 0 && (m_snap >> (4 * d)) == 16'h0)
                e.seg = 7'h00;
            else
                e.seg = seg_tab[(m_snap >> (4 * d)) & 16'hF];
        end
        return e;
    endfunction

    // Applies one cycle of inputs at the falling edge and queues the display expected after the next rise.
    task automatic step(input logic e, input logic blz, input logic [15:0] v, input logic r);
        @(negedge clk);
        bus.en       = e;
        bus.blank_lz = blz;
        bus.bcd_in   = v;
        rst          = r;
        if (r) begin
            m_scan = 0;
            m_k    = 0;
            m_snap = '0;
            #1;
            check("rst_an", 32'(bus.an), 32'h0);
            check("rst_seg", 32'(bus.seg), 32'h0);
            check("rst_fd", 32'(bus.frame_done), 32'h0);
        end else if (!m_scan) begin
            if (e) begin
                m_scan = 1;
                m_k    = 0;
                m_snap = v;
            end
        end else if (!e) begin
            m_scan = 0;
        end else begin
            m_k++;
            if (m_k % FRAME == 0) m_snap = v;
        end
        exp_q.push_back(predict(blz));
    endtask

    task automatic run(input int n, input logic blz, input logic [15:0] v);
        for (int i = 0; i < n; i++) step(1'b1, blz, v, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("an", 32'(bus.an), 32'(e.an));
                check("seg", 32'(bus.seg), 32'(e.seg));
                check("frame_done", 32'(bus.frame_done), 32'(e.fd));
            end
        end
    end

    initial begin : driver
        logic [15:0] v;
        logic        blz;
        bus.en       = 1'b0;
        bus.blank_lz = 1'b0;
        bus.bcd_in   = '0;
        #1;
        check("por_an", 32'(bus.an), 32'h0);
        check("por_seg", 32'(bus.seg), 32'h0);
        check("por_fd", 32'(bus.frame_done), 32'h0);

        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);

        run(20, 1'b0, 16'h1234);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        run(18, 1'b1, 16'h0307);
        step(1'b0, 1'b1, 16'h0, 1'b0);
        run(18, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0, 1'b0);

        run(6, 1'b0, 16'h1111);
        run(28, 1'b0, 16'h9999);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        run(18, 1'b0, 16'h00A5);
        run(6, 1'b1, 16'h00A5);

        step(1'b0, 1'b0, 16'h0, 1'b0);
        run(10, 1'b0, 16'h4321);
        step(1'b0, 1'b0, 16'h4321, 1'b0);
        step(1'b0, 1'b0, 16'h4321, 1'b0);
        run(20, 1'b0, 16'h5678);
        run(7, 1'b0, 16'h8765);
        step(1'b1, 1'b0, 16'h8765, 1'b1);
        step(1'b1, 1'b0, 16'h8765, 1'b0);
        run(20, 1'b0, 16'h2468);

        blz = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            v = '0;
            for (int j = 0; j < ND; j++)
                if ($urandom_range(0, 2) != 0) v[4*j +: 4] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) blz = ~blz;
            step($urandom_range(0, 39) != 0, blz, v, $urandom_range(0, 299) == 0);
        end

        step(1'b0, 1'b0, 16'h0, 1'b0);
        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
